// File: rtl/gen_datapath_pkg.sv
// Shared encodings for the gen_datapath slice: ALU opcodes, bus source/load
// indices and the iterative-ALU state machine.
package gen_datapath_pkg;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  localparam int unsigned OE_HI     = 0;
  localparam int unsigned OE_LO     = 1;
  localparam int unsigned OE_ZHI    = 2;
  localparam int unsigned OE_ZLO    = 3;
  localparam int unsigned OE_PC     = 4;
  localparam int unsigned OE_MDR    = 5;
  localparam int unsigned OE_INPORT = 6;
  localparam int unsigned OE_C      = 7;

  localparam int unsigned IE_MAR     = 0;
  localparam int unsigned IE_MDR     = 1;
  localparam int unsigned IE_HI      = 2;
  localparam int unsigned IE_LO      = 3;
  localparam int unsigned IE_Y       = 4;
  localparam int unsigned IE_PC      = 5;
  localparam int unsigned IE_IR      = 6;
  localparam int unsigned IE_OUTPORT = 7;
  localparam int unsigned IE_INPORT  = 8;
  localparam int unsigned IE_CON     = 9;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} alu_state_e;

endpackage

// File: rtl/gen_datapath_alu.sv
// ALU with Z register: single-cycle logic/arith ops plus signed iterative
// MUL (shift-add) and DIV (restoring) on sign-magnitude operands.
module gen_datapath_alu
  import gen_datapath_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [4:0]    op_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          div0_o,
  output logic [DW-1:0] zhi_o,
  output logic [DW-1:0] zlo_o
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
  localparam logic [DW-1:0] DW_V = DW'(DW);

  alu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]     mc_q, mc_d;
  logic              qneg_q, qneg_d, rneg_q, rneg_d;
  logic [DW-1:0]     zhi_q, zhi_d, zlo_q, zlo_d;
  logic              div0_q, div0_d;

  logic [DW-1:0]     a_abs, b_abs, res, quo, rem;
  logic [6:0]        sh;
  logic [DW:0]       mul_sum, div_sh, div_tr;
  logic [2*DW-1:0]   mul_nxt, div_nxt, prod;

  always_comb begin
    sh  = 7'(b_i % DW_V);
    res = '0;
    case (op_i)
      OP_ADD:  res = a_i + b_i;
      OP_SUB:  res = a_i - b_i;
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_SHR:  res = a_i >> sh;
      OP_SHRA: res = $signed(a_i) >>> sh;
      OP_SHL:  res = a_i << sh;
      OP_ROR:  res = (a_i >> sh) | (a_i << (7'(DW) - sh));
      OP_ROL:  res = (a_i << sh) | (a_i >> (7'(DW) - sh));
      OP_NEG:  res = '0 - a_i;
      OP_NOT:  res = ~a_i;
      default: res = '0;
    endcase
  end

  // acc holds {partial/remainder, multiplier/quotient}; one bit per cycle.
  always_comb begin
    a_abs   = a_i[DW-1] ? ('0 - a_i) : a_i;
    b_abs   = b_i[DW-1] ? ('0 - b_i) : b_i;
    mul_sum = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, mc_q} : '0);
    mul_nxt = {mul_sum, acc_q[DW-1:1]};
    prod    = qneg_q ? ('0 - mul_nxt) : mul_nxt;
    div_sh  = {acc_q[2*DW-1:DW], acc_q[DW-1]};
    div_tr  = div_sh - {1'b0, mc_q};
    div_nxt = div_tr[DW] ? {div_sh[DW-1:0], acc_q[DW-2:0], 1'b0}
                         : {div_tr[DW-1:0], acc_q[DW-2:0], 1'b1};
    quo     = qneg_q ? ('0 - div_nxt[DW-1:0]) : div_nxt[DW-1:0];
    rem     = rneg_q ? ('0 - div_nxt[2*DW-1:DW]) : div_nxt[2*DW-1:DW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    div0_d  = div0_q;
    case (state_q)
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          {zhi_d, zlo_d} = prod;
          state_d = DONE;
        end
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          zlo_d   = quo;
          zhi_d   = rem;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        if (start_i) begin
          cnt_d = '0;
          case (op_i)
            OP_MUL: begin
              acc_d   = {{DW{1'b0}}, b_abs};
              mc_d    = a_abs;
              qneg_d  = a_i[DW-1] ^ b_i[DW-1];
              state_d = MUL;
            end
            OP_DIV: begin
              if (b_i == '0) begin
                zlo_d   = '1;
                zhi_d   = a_i;
                div0_d  = 1'b1;
                state_d = DONE;
              end else begin
                acc_d   = {{DW{1'b0}}, a_abs};
                mc_d    = b_abs;
                qneg_d  = a_i[DW-1] ^ b_i[DW-1];
                rneg_d  = a_i[DW-1];
                state_d = DIV;
              end
            end
            default: begin
              zlo_d   = res;
              zhi_d   = '0;
              state_d = DONE;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zhi_q   <= '0;
      zlo_q   <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      div0_q  <= div0_d;
    end
  end

  assign busy_o = (state_q == MUL) || (state_q == DIV);
  assign done_o = (state_q == DONE);
  assign div0_o = div0_q;
  assign zhi_o  = zhi_q;
  assign zlo_o  = zlo_q;

endmodule

// File: rtl/gen_datapath.sv
// Single-bus CPU datapath: GPR file, special registers, bus mux with
// contention detect, branch-condition flop and the iterative ALU.
module gen_datapath
  import gen_datapath_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = 9
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          gra,
  input  logic          grb,
  input  logic          grc,
  input  logic          rin,
  input  logic          rout,
  input  logic          baout,
  input  logic [7:0]    out_en,
  input  logic [9:0]    in_en,
  input  logic          inc_pc,
  input  logic [4:0]    alu_op,
  input  logic          alu_start,
  output logic          alu_busy,
  output logic          alu_done,
  output logic          div0,
  output logic          mem_read,
  output logic          mem_write,
  input  logic          read,
  input  logic          write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] inport_data,
  output logic [DW-1:0] outport_data,
  output logic [DW-1:0] ir_out,
  output logic          con,
  output logic          bus_err
);

  localparam int RW = $clog2(NREG);

  logic [DW-1:0] hi_q, lo_q, y_q, pc_q, ir_q, mdr_q, outport_q, inport_q;
  logic [AW-1:0] mar_q;
  logic          con_q, con_d;
  logic [DW-1:0] gpr_q [NREG];
  logic [DW-1:0] zhi, zlo, bus, bus_or, c_src, gpr_val;
  logic [26:0]   ir_f;
  logic [RW-1:0] sel;
  logic          gpr_oe;

  // Narrow-DW builds zero-fill the upper IR field bits.
  assign ir_f  = 27'(ir_q);
  assign c_src = DW'($signed(ir_f[18:0]));
  assign sel   = (gra ? RW'(ir_f[26:23]) : '0)
               | (grb ? RW'(ir_f[22:19]) : '0)
               | (grc ? RW'(ir_f[18:15]) : '0);

  assign gpr_oe  = rout | baout;
  assign gpr_val = (baout && sel == '0) ? '0 : gpr_q[sel];

  always_comb begin
    bus_or = '0;
    if (out_en[OE_HI])     bus_or |= hi_q;
    if (out_en[OE_LO])     bus_or |= lo_q;
    if (out_en[OE_ZHI])    bus_or |= zhi;
    if (out_en[OE_ZLO])    bus_or |= zlo;
    if (out_en[OE_PC])     bus_or |= pc_q;
    if (out_en[OE_MDR])    bus_or |= mdr_q;
    if (out_en[OE_INPORT]) bus_or |= inport_q;
    if (out_en[OE_C])      bus_or |= c_src;
    if (gpr_oe)            bus_or |= gpr_val;
    bus_err = $countones({out_en, gpr_oe}) > 1;
    bus     = bus_err ? '0 : bus_or;
  end

  for (genvar k = 0; k < NREG; k++) begin : g_gpr
    always_ff @(posedge clk or negedge clr) begin
      if (!clr)                         gpr_q[k] <= '0;
      else if (rin && sel == RW'(k))    gpr_q[k] <= bus;
    end
  end

  always_comb begin
    case (ir_f[20:19])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[DW-1];
      default: con_d = bus[DW-1];
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hi_q      <= '0;
      lo_q      <= '0;
      y_q       <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      mar_q     <= '0;
      outport_q <= '0;
      inport_q  <= '0;
      con_q     <= 1'b0;
    end else begin
      if (in_en[IE_HI])      hi_q      <= bus;
      if (in_en[IE_LO])      lo_q      <= bus;
      if (in_en[IE_Y])       y_q       <= bus;
      if (in_en[IE_IR])      ir_q      <= bus;
      if (in_en[IE_MAR])     mar_q     <= AW'(bus);
      if (in_en[IE_OUTPORT]) outport_q <= bus;
      if (in_en[IE_INPORT])  inport_q  <= inport_data;
      if (in_en[IE_CON])     con_q     <= con_d;
      if (read)              mdr_q     <= mem_rdata;
      else if (in_en[IE_MDR]) mdr_q    <= bus;
      if (in_en[IE_PC])      pc_q      <= bus;
      else if (inc_pc)       pc_q      <= pc_q + 1'b1;
    end
  end

  gen_datapath_alu #(.DW(DW)) u_alu (
    .clk     (clk),
    .clr     (clr),
    .op_i    (alu_op),
    .start_i (alu_start),
    .a_i     (y_q),
    .b_i     (bus),
    .busy_o  (alu_busy),
    .done_o  (alu_done),
    .div0_o  (div0),
    .zhi_o   (zhi),
    .zlo_o   (zlo)
  );

  assign mem_read     = read;
  assign mem_write    = write;
  assign mem_addr     = mar_q;
  assign mem_wdata    = mdr_q;
  assign outport_data = outport_q;
  assign ir_out       = ir_q;
  assign con          = con_q;

endmodule

// File: tb/tb_gen_datapath.sv
// Directed-vector bench for gen_datapath (DW=32, NREG=16, AW=9).
module tb_gen_datapath;
  import gen_datapath_pkg::*;

  localparam logic [7:0] O_HI = 8'h01, O_LO = 8'h02, O_ZHI = 8'h04, O_ZLO = 8'h08;
  localparam logic [7:0] O_PC = 8'h10, O_MDR = 8'h20, O_IN = 8'h40, O_C = 8'h80;
  localparam logic [9:0] I_MAR = 10'h001, I_MDR = 10'h002, I_Y = 10'h010, I_PC = 10'h020;
  localparam logic [9:0] I_IR = 10'h040, I_OUT = 10'h080, I_IN = 10'h100, I_CON = 10'h200;

  localparam logic [4:0]  T_OP [11] = '{OP_SUB, OP_SHRA, OP_SHR, OP_ROL, OP_ROR, OP_SHL,
                                        OP_AND, OP_OR, OP_NEG, OP_NOT, 5'd31};
  localparam logic [31:0] T_B  [11] = '{32'd2, 32'd33, 32'd4, 32'd1, 32'd36, 32'd1,
                                        32'hFF, 32'h10, 32'd0, 32'd0, 32'd5};
  localparam logic [31:0] T_Z  [11] = '{32'h7FFF_FFFF, 32'hC000_0000, 32'h0800_0000,
                                        32'h0000_0003, 32'h1800_0000, 32'h0000_0002,
                                        32'h0000_0001, 32'h8000_0011, 32'h7FFF_FFFF,
                                        32'h7FFF_FFFE, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        clr;
  logic        gra, grb, grc, rin, rout, baout;
  logic [7:0]  out_en;
  logic [9:0]  in_en;
  logic        inc_pc, alu_start, read, write;
  logic [4:0]  alu_op;
  logic        alu_busy, alu_done, div0, mem_read, mem_write, con, bus_err;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, inport_data, outport_data, ir_out;

  int nvec = 0;
  int nmis = 0;

  gen_datapath #(.DW(32), .NREG(16), .AW(9)) dut (
    .clk(clk), .clr(clr), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .baout(baout), .out_en(out_en), .in_en(in_en), .inc_pc(inc_pc), .alu_op(alu_op),
    .alu_start(alu_start), .alu_busy(alu_busy), .alu_done(alu_done), .div0(div0),
    .mem_read(mem_read), .mem_write(mem_write), .read(read), .write(write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .inport_data(inport_data), .outport_data(outport_data), .ir_out(ir_out),
    .con(con), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    out_en = '0; in_en = '0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; baout = 0;
    inc_pc = 0; alu_start = 0; alu_op = OP_ADD; read = 0; write = 0;
  endtask

  task automatic put(input logic [31:0] v);
    inport_data = v; in_en = I_IN; step(); in_en = '0;
  endtask

  task automatic load(input logic [31:0] v, input logic [9:0] ie);
    put(v); out_en = O_IN; in_en = ie; step(); idle();
  endtask

  task automatic peek(input logic [7:0] oe, output logic [31:0] v);
    out_en = oe; in_en = I_OUT; step(); v = outport_data; idle();
  endtask

  task automatic run_wait(output int nbusy, output logic seen);
    nbusy = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (alu_done) begin seen = 1; break; end
      if (alu_busy) nbusy++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          nb;
    logic        seen;

    clr = 0; idle(); inport_data = '0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_busy", alu_busy, 0);
    check_eq("rst_done", alu_done, 0);
    check_eq("rst_div0", div0, 0);
    check_eq("rst_ir", ir_out, 0);
    check_eq("rst_addr", mem_addr, 0);
    clr = 1; step();

    // ADD through GPR fields: ra=2, rb=3
    load(32'h0118_0000, I_IR);
    check_eq("ir_load", ir_out, 32'h0118_0000);
    put(32'd5); out_en = O_IN; gra = 1; rin = 1; step(); idle();
    put(32'd7); out_en = O_IN; grb = 1; rin = 1; step(); idle();
    gra = 1; rout = 1; peek(8'h00, v);
    check_eq("r2_read", v, 32'd5);
    gra = 1; rout = 1; in_en = I_Y; step(); idle();
    grb = 1; rout = 1; alu_op = OP_ADD; alu_start = 1; step(); idle();
    check_eq("add_done", alu_done, 1);
    peek(O_ZLO, v); check_eq("add_zlo", v, 32'd12);
    check_eq("done_pulse", alu_done, 0);
    peek(O_ZHI, v); check_eq("add_zhi", v, 32'd0);

    // Single-cycle op table, Y = 0x80000001
    load(32'h8000_0001, I_Y);
    for (int i = 0; i < 11; i++) begin
      put(T_B[i]); out_en = O_IN; alu_op = T_OP[i]; alu_start = 1; step(); idle();
      check_eq($sformatf("op%0d_done", T_OP[i]), alu_done, 1);
      peek(O_ZLO, v); check_eq($sformatf("op%0d_zlo", T_OP[i]), v, T_Z[i]);
    end
    peek(O_ZHI, v); check_eq("undef_zhi", v, 32'd0);

    // MUL -3 * 100000 with an ignored start and a Y change mid-op
    load(32'hFFFF_FFFD, I_Y);
    put(32'd100000); out_en = O_IN; alu_op = OP_MUL; alu_start = 1; step(); idle();
    nb = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (alu_done) begin seen = 1; break; end
      if (alu_busy) nb++;
      idle();
      if (i == 3) begin inport_data = 32'd77; in_en = I_IN; end
      if (i == 5) begin out_en = O_IN; in_en = I_Y; alu_op = OP_ADD; alu_start = 1; end
      step();
    end
    idle();
    check_eq("mul_done", seen, 1);
    check_eq("mul_busy_cycles", nb, 32);
    peek(O_ZLO, v); check_eq("mul_zlo", v, 32'hFFFB_6C20);
    peek(O_ZHI, v); check_eq("mul_zhi", v, 32'hFFFF_FFFF);
    check_eq("mul_no_redone", alu_done, 0);

    // DIV -17 / 5, then divide by zero
    load(32'hFFFF_FFEF, I_Y);
    put(32'd5); out_en = O_IN; alu_op = OP_DIV; alu_start = 1; step(); idle();
    run_wait(nb, seen);
    check_eq("div_done", seen, 1);
    check_eq("div_busy_cycles", nb, 32);
    peek(O_ZLO, v); check_eq("div_quo", v, 32'hFFFF_FFFD);
    peek(O_ZHI, v); check_eq("div_rem", v, 32'hFFFF_FFFE);
    check_eq("div0_clear", div0, 0);
    load(32'd1234, I_Y);
    out_en = '0; alu_op = OP_DIV; alu_start = 1; step(); idle();
    check_eq("dz_done", alu_done, 1);
    check_eq("dz_busy", alu_busy, 0);
    check_eq("dz_flag", div0, 1);
    peek(O_ZLO, v); check_eq("dz_zlo", v, 32'hFFFF_FFFF);
    peek(O_ZHI, v); check_eq("dz_zhi", v, 32'd1234);
    check_eq("dz_sticky", div0, 1);

    // Bus contention and empty bus
    out_en = O_PC | O_MDR; in_en = I_OUT; #1;
    check_eq("err_two", bus_err, 1);
    step(); idle();
    check_eq("err_bus0", outport_data, 0);
    out_en = O_IN; rout = 1; #1;
    check_eq("err_gpr", bus_err, 1);
    idle();
    peek(O_IN, v);
    out_en = '0; in_en = I_OUT; #1;
    check_eq("err_none", bus_err, 0);
    step(); idle();
    check_eq("none_bus0", outport_data, 0);

    // CON on sign bit, PC wrap
    load(32'h0018_0000, I_IR);
    load(32'h8000_0000, I_CON);
    check_eq("con_neg", con, 1);
    load(32'd1, I_CON);
    check_eq("con_pos", con, 0);
    load(32'hFFFF_FFFF, I_PC);
    peek(O_PC, v); check_eq("pc_load", v, 32'hFFFF_FFFF);
    inc_pc = 1; step(); idle();
    peek(O_PC, v); check_eq("pc_wrap", v, 32'd0);

    // Memory interface: MAR width, MDR read priority
    load(32'h3FF, I_MAR);
    check_eq("mar_trunc", mem_addr, 9'h1FF);
    mem_rdata = 32'hA5A5_5A5A; read = 1; write = 1; out_en = O_IN; in_en = I_MDR; #1;
    check_eq("mem_read", mem_read, 1);
    check_eq("mem_write", mem_write, 1);
    step(); idle();
    check_eq("mdr_read_pri", mem_wdata, 32'hA5A5_5A5A);
    out_en = O_IN; in_en = I_MDR; step(); idle();
    check_eq("mdr_bus", mem_wdata, 32'h3FF);

    // C sign extension and R0 under baout
    load(32'h0004_0000, I_IR);
    peek(O_C, v); check_eq("c_sext", v, 32'hFFFC_0000);
    put(32'd9); out_en = O_IN; gra = 1; rin = 1; step(); idle();
    gra = 1; rout = 1; peek(8'h00, v); check_eq("r0_rout", v, 32'd9);
    gra = 1; baout = 1; peek(8'h00, v); check_eq("r0_baout", v, 32'd0);

    // Reset during MUL, then a clean ADD
    load(32'hFFFF_FFFD, I_Y);
    put(32'd100000); out_en = O_IN; alu_op = OP_MUL; alu_start = 1; step(); idle();
    repeat (10) step();
    check_eq("mid_busy", alu_busy, 1);
    clr = 0; #1;
    check_eq("rst_mid_busy", alu_busy, 0);
    check_eq("rst_mid_done", alu_done, 0);
    step(); step();
    clr = 1; step();
    peek(O_ZLO, v); check_eq("rst_zlo", v, 32'd0);
    peek(O_ZHI, v); check_eq("rst_zhi", v, 32'd0);
    load(32'd20, I_Y);
    put(32'd22); out_en = O_IN; alu_op = OP_ADD; alu_start = 1; step(); idle();
    check_eq("post_add_done", alu_done, 1);
    peek(O_ZLO, v); check_eq("post_add_zlo", v, 32'd42);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
